ni_packetizer_dsb: RTL and testbench

- Network-interface injector for the DSB router local (P) input port.
- Accepts a packet descriptor plus a payload word stream, then emits a HEAD flit followed by BODY flits and a final TAIL flit.
- Flit format matches what the router's XY header decode stage consumes.
- Also converts {x,y} coordinates to the linear destination ID the router decodes as id % `NoC_SIZE / id / `NoC_SIZE.

---
 rtl/ni_packetizer_dsb.sv | 184 ++++++++++++++++++
 tb/tb_ni_packetizer_dsb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer_dsb.sv
// rtl/ni_packetizer_dsb.sv - DSB local-port injector: descriptor + payload stream to HEAD/BODY/TAIL flits.
// Optional NI_SEQ_NUM_EN adds an 8-bit per-node packet sequence number in head flit [47:40].

`ifndef FLIT_LENGTH
`define FLIT_LENGTH 66
`endif
`ifndef NoC_SIZE
`define NoC_SIZE 4
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module ni_packetizer_dsb #(
    parameter int MAX_LEN = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [5:0]              local_addr,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [2:0]              pkt_dest_x,
    input  logic [2:0]              pkt_dest_y,
    input  logic [3:0]              pkt_len,
    input  logic                    pld_valid,
    output logic                    pld_ready,
    input  logic [63:0]             pld_data,
    input  logic                    out_full,
    output logic                    out_valid,
    output logic [`FLIT_LENGTH-1:0] out_flit,
    output logic                    err_dest
);

    localparam int         FL   = `FLIT_LENGTH;
    localparam logic [3:0] NOC4 = 4'(`NoC_SIZE);
    localparam logic [5:0] NOC6 = 6'(`NoC_SIZE);
    localparam logic [3:0] LMAX = 4'(MAX_LEN);

    typedef enum logic [2:0] {S_IDLE, S_HEAD, S_BODY, S_PAD, S_DRAIN} state_t;

    state_t      state_q, state_d;
    logic [5:0]  dest_id_q, dest_id_d;
    logic [5:0]  src_id_q, src_id_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  rem_q, rem_d;
    logic        err_q, err_d;
    logic [7:0]  seq_field;

    logic        dest_bad;
    logic [3:0]  len_in;

`ifdef NI_SEQ_NUM_EN
    logic [7:0]  seq_q, seq_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dest_id_q <= '0;
            src_id_q  <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            err_q     <= 1'b0;
`ifdef NI_SEQ_NUM_EN
            seq_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            dest_id_q <= dest_id_d;
            src_id_q  <= src_id_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            err_q     <= err_d;
`ifdef NI_SEQ_NUM_EN
            seq_q     <= seq_d;
`endif
        end
    end

    assign dest_bad = ({1'b0, pkt_dest_x} >= NOC4) || ({1'b0, pkt_dest_y} >= NOC4);
    assign len_in   = (pkt_len > LMAX) ? LMAX : pkt_len;

    always_comb begin
        state_d   = state_q;
        dest_id_d = dest_id_q;
        src_id_d  = src_id_q;
        len_d     = len_q;
        rem_d     = rem_q;
        err_d     = 1'b0;
`ifdef NI_SEQ_NUM_EN
        seq_d     = seq_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pkt_valid && pkt_ready) begin
                    dest_id_d = {3'b0, pkt_dest_y} * NOC6 + {3'b0, pkt_dest_x};
                    src_id_d  = {3'b0, local_addr[2:0]} * NOC6 + {3'b0, local_addr[5:3]};
                    len_d     = len_in;
                    rem_d     = len_in;
                    if (dest_bad) begin
                        // Dropped packets still have their payload swallowed so upstream stays aligned.
                        err_d   = 1'b1;
                        state_d = (len_in != 4'd0) ? S_DRAIN : S_IDLE;
                    end else begin
                        state_d = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (!out_full) begin
                    state_d = (len_q != 4'd0) ? S_BODY : S_PAD;
`ifdef NI_SEQ_NUM_EN
                    seq_d   = seq_q + 8'd1;
`endif
                end
            end
            S_BODY: begin
                if (pld_valid && !out_full) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = S_IDLE;
                end
            end
            S_PAD: begin
                if (!out_full) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (pld_valid) begin
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef NI_SEQ_NUM_EN
    assign seq_field = seq_q;
`else
    assign seq_field = 8'h00;
`endif

    always_comb begin
        // rst_n gating keeps the descriptor port closed while reset is held.
        pkt_ready = 1'b0;
        pld_ready = 1'b0;
        out_valid = 1'b0;
        out_flit  = '0;
        case (state_q)
            S_IDLE: begin
                pkt_ready = rst_n;
            end
            S_HEAD: begin
                out_valid           = 1'b1;
                out_flit[FL-1:FL-2] = `HEAD;
                out_flit[63:0]      = {dest_id_q, src_id_q, len_q, seq_field, 40'b0};
            end
            S_BODY: begin
                out_valid           = pld_valid;
                pld_ready           = !out_full;
                out_flit[FL-1:FL-2] = (rem_q == 4'd1) ? `TAIL : `BODY;
                out_flit[63:0]      = pld_data;
            end
            S_PAD: begin
                out_valid           = 1'b1;
                out_flit[FL-1:FL-2] = `TAIL;
            end
            S_DRAIN: begin
                pld_ready = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign err_dest = err_q;

endmodule

// File: tb/tb_ni_packetizer_dsb.sv
// tb/tb_ni_packetizer_dsb.sv - scoreboard bench for ni_packetizer_dsb.

`ifndef FLIT_LENGTH
`define FLIT_LENGTH 66
`endif
`ifndef NoC_SIZE
`define NoC_SIZE 4
`endif
`ifndef HEAD
`define HEAD 2'b10
`endif
`ifndef BODY
`define BODY 2'b00
`endif
`ifndef TAIL
`define TAIL 2'b01
`endif

module tb_ni_packetizer_dsb;

    typedef logic [`FLIT_LENGTH-1:0] flit_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  local_addr = {3'd1, 3'd1};
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [2:0]  pkt_dest_x = '0;
    logic [2:0]  pkt_dest_y = '0;
    logic [3:0]  pkt_len = '0;
    logic        pld_valid = 1'b0;
    logic        pld_ready;
    logic [63:0] pld_data = '0;
    logic        out_full = 1'b0;
    logic        out_valid;
    flit_t       out_flit;
    logic        err_dest;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          err_cnt = 0;
    int          ov_cnt = 0;
    int          acc_cyc = 0;
    logic [7:0]  seq_nxt = 8'd0;
    flit_t       sb[$];
    int          xfer_cyc[$];

    ni_packetizer_dsb #(.MAX_LEN(15)) dut (
        .clk(clk), .rst_n(rst_n), .local_addr(local_addr),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_dest_x(pkt_dest_x), .pkt_dest_y(pkt_dest_y), .pkt_len(pkt_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .out_full(out_full), .out_valid(out_valid), .out_flit(out_flit),
        .err_dest(err_dest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s timeout", nm);
    endtask

    // Monitor: every accepted flit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (err_dest) err_cnt++;
        if (out_valid) ov_cnt++;
        if (out_valid && !out_full) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_flit actual=%h expected=none", out_flit);
            end else begin
                chk("flit", out_flit, sb.pop_front());
                xfer_cyc.push_back(cyc);
            end
        end
    end

    function automatic flit_t mk_head(input logic [5:0] d, input logic [5:0] s, input logic [3:0] l);
        flit_t f = '0;
        f[`FLIT_LENGTH-1:`FLIT_LENGTH-2] = `HEAD;
        f[63:58] = d;
        f[57:52] = s;
        f[51:48] = l;
        return f;
    endfunction

    function automatic flit_t mk_data(input logic [1:0] t, input logic [63:0] d);
        flit_t f = '0;
        f[`FLIT_LENGTH-1:`FLIT_LENGTH-2] = t;
        f[63:0] = d;
        return f;
    endfunction

    // Expected head carrying the bench's own sequence model.
    task automatic exp_head(input logic [5:0] d, input logic [5:0] s, input logic [3:0] l);
        flit_t f = mk_head(d, s, l);
`ifdef NI_SEQ_NUM_EN
        f[47:40] = seq_nxt;
        seq_nxt  = seq_nxt + 8'd1;
`endif
        sb.push_back(f);
    endtask

    task automatic send_desc(input logic [2:0] x, input logic [2:0] y, input logic [3:0] l);
        int t = 0;
        @(negedge clk);
        pkt_valid = 1'b1; pkt_dest_x = x; pkt_dest_y = y; pkt_len = l;
        while (!pkt_ready && t < 100) begin @(negedge clk); t++; end
        if (!pkt_ready) timeout_fail("pkt_ready");
        acc_cyc = cyc;
        @(posedge clk); #1;
        pkt_valid = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w);
        int t = 0;
        @(negedge clk);
        pld_valid = 1'b1; pld_data = w;
        while (!pld_ready && t < 100) begin @(negedge clk); t++; end
        if (!pld_ready) timeout_fail("pld_ready");
        @(posedge clk); #1;
        pld_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin @(posedge clk); t++; end
        chk(nm, sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_pkt_ready", pkt_ready, 1'b0);
        chk("rst_pld_ready", pld_ready, 1'b0);
        chk("rst_err_dest", err_dest, 1'b0);
        chk("rst_out_flit", out_flit, '0);
        sb.delete();
        seq_nxt = 8'd0;
        rst_n = 1'b1;
    endtask

    initial begin
        int e0, o0;
        flit_t hf;

        repeat (3) @(posedge clk);
        do_reset();

        // Basic packet: dest (2,3) -> 14, src (1,1) -> 5, len 2, back-to-back flits.
        xfer_cyc.delete();
        exp_head(6'd14, 6'd5, 4'd2);
        sb.push_back(mk_data(`BODY, 64'hAAAA_0000_1111_2222));
        sb.push_back(mk_data(`TAIL, 64'hBBBB_3333_4444_5555));
        fork
            send_desc(3'd2, 3'd3, 4'd2);
            begin
                push_word(64'hAAAA_0000_1111_2222);
                push_word(64'hBBBB_3333_4444_5555);
            end
        join
        wait_drain("basic_drain");
        chk("basic_nxfer", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("head_latency", xfer_cyc[0], acc_cyc + 1);
            chk("body_cycle", xfer_cyc[1], acc_cyc + 2);
            chk("tail_cycle", xfer_cyc[2], acc_cyc + 3);
        end

        // Same packet with 3-cycle stalls during HEAD and during BODY/TAIL.
        hf = mk_head(6'd14, 6'd5, 4'd2);
`ifdef NI_SEQ_NUM_EN
        hf[47:40] = seq_nxt;
`endif
        exp_head(6'd14, 6'd5, 4'd2);
        sb.push_back(mk_data(`BODY, 64'h0123_4567_89AB_CDEF));
        sb.push_back(mk_data(`TAIL, 64'hFEDC_BA98_7654_3210));
        @(negedge clk);
        chk("stall_pkt_ready", pkt_ready, 1'b1);
        pkt_valid = 1'b1; pkt_dest_x = 3'd2; pkt_dest_y = 3'd3; pkt_len = 4'd2;
        @(posedge clk); #1;
        pkt_valid = 1'b0; out_full = 1'b1;
        pld_valid = 1'b1; pld_data = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_head_valid", out_valid, 1'b1);
            chk("stall_head_flit", out_flit, hf);
            chk("stall_head_pld_ready", pld_ready, 1'b0);
            @(posedge clk);
        end
        #1 out_full = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        pld_data = 64'hFEDC_BA98_7654_3210; out_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_tail_flit", out_flit, mk_data(`TAIL, 64'hFEDC_BA98_7654_3210));
            chk("stall_tail_pld_ready", pld_ready, 1'b0);
            @(posedge clk);
        end
        #1 out_full = 1'b0;
        @(posedge clk); #1;
        pld_valid = 1'b0;
        wait_drain("stall_drain");

        // Zero-length packet to (0,0): HEAD len 0 then zero TAIL, then idle again.
        exp_head(6'd0, 6'd5, 4'd0);
        sb.push_back(mk_data(`TAIL, 64'h0));
        send_desc(3'd0, 3'd0, 4'd0);
        wait_drain("len0_drain");
        @(negedge clk);
        chk("len0_pkt_ready", pkt_ready, 1'b1);

        // Out-of-mesh destination: one err pulse, payload swallowed, no flits.
        e0 = err_cnt; o0 = ov_cnt;
        fork
            send_desc(3'd4, 3'd1, 4'd3);
            begin
                push_word(64'h1);
                push_word(64'h2);
                push_word(64'h3);
            end
        join
        repeat (3) @(posedge clk);
        chk("err_pulses", err_cnt - e0, 1);
        chk("err_no_out_valid", ov_cnt - o0, 0);
        @(negedge clk);
        chk("err_back_idle", pkt_ready, 1'b1);

        // Reset mid-packet after the first BODY flit of a len=4 packet.
        exp_head(6'd15, 6'd5, 4'd4);
        sb.push_back(mk_data(`BODY, 64'hC0DE_0001));
        fork
            send_desc(3'd3, 3'd3, 4'd4);
            push_word(64'hC0DE_0001);
        join
        do_reset();
        exp_head(6'd3, 6'd5, 4'd1);
        sb.push_back(mk_data(`TAIL, 64'hD00D_0002));
        fork
            send_desc(3'd3, 3'd0, 4'd1);
            push_word(64'hD00D_0002);
        join
        wait_drain("post_reset_drain");

        // 257 zero-length packets to (1,2) -> 9: sequence wraps 255 -> 0 when enabled.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            exp_head(6'd9, 6'd5, 4'd0);
            sb.push_back(mk_data(`TAIL, 64'h0));
            send_desc(3'd1, 3'd2, 4'd0);
        end
        wait_drain("seq_drain");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
